// File: rtl/multi_signed.sv
// Two-stage pipelined signed multiplier. Stage 1 registers the operands and
// stage 2 registers the radix-4 Booth product of those operands.
module multi_signed #(
   parameter int width = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [width-1:0]     A,
   input  logic [width-1:0]     B,
   output logic                 out_valid,
   output logic [2*width-1:0]   P
);

   localparam int          PW  = 2 * width;
   localparam int unsigned NPP = (width + 1) / 2;
   localparam int          BW  = 2 * NPP;
   localparam logic [PW-1:0] ONE = {{(PW-1){1'b0}}, 1'b1};

   logic [width-1:0] a_q, a_d;
   logic [width-1:0] b_q, b_d;
   logic             s1_valid_q, s1_valid_d;
   logic             out_valid_q, out_valid_d;
   logic [PW-1:0]    p_q, p_d;
   logic [PW-1:0]    prod;

   // B is sign-extended to an even width so odd widths recode cleanly.
   // -2X is formed as (~X + 1) << 1.
   always_comb begin : booth
      logic [PW-1:0] a_ext;
      logic [PW-1:0] neg_a;
      logic [PW-1:0] pp;
      logic [BW:0]   b_rec;
      a_ext = PW'($signed(a_q));
      neg_a = ~a_ext + ONE;
      b_rec = {BW'($signed(b_q)), 1'b0};
      pp    = '0;
      prod  = '0;
      for (int unsigned i = 0; i < NPP; i++) begin
         case (b_rec[2*i +: 3])
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext << 1;
            3'b100:         pp = neg_a << 1;
            3'b101, 3'b110: pp = neg_a;
            default:        pp = '0;
         endcase
         prod = prod + (pp << (2 * i));
      end
   end

   always_comb begin
      a_d         = a_q;
      b_d         = b_q;
      if (in_valid) begin
         a_d = A;
         b_d = B;
      end
      s1_valid_d  = in_valid;
      out_valid_d = s1_valid_q;
      p_d         = s1_valid_q ? prod : p_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q         <= '0;
         b_q         <= '0;
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         p_q         <= '0;
      end else begin
         a_q         <= a_d;
         b_q         <= b_d;
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         p_q         <= p_d;
      end
   end

   assign out_valid = out_valid_q;
   assign P         = p_q;

endmodule

// File: tb/tb_multi_signed.sv
// Bench for multi_signed: width 10 directed/random traffic plus exhaustive
// width 4 and width 5 instances, checked against a queue of expected products.
module tb_multi_signed;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        in_valid10, ov10;
   logic [9:0]  A10, B10;
   logic [19:0] P10;
   logic        in_valid4, ov4;
   logic [3:0]  A4, B4;
   logic [7:0]  P4;
   logic        in_valid5, ov5;
   logic [4:0]  A5, B5;
   logic [9:0]  P5;

   logic [63:0] q10[$];
   logic [63:0] q4[$];
   logic [63:0] q5[$];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   multi_signed #(.width(10)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid10),
      .A(A10), .B(B10), .out_valid(ov10), .P(P10));
   multi_signed #(.width(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4),
      .A(A4), .B(B4), .out_valid(ov4), .P(P4));
   multi_signed #(.width(5)) u5 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid5),
      .A(A5), .B(B5), .out_valid(ov5), .P(P5));

   function automatic logic [63:0] prod(input int a, input int b, input int w);
      longint      p;
      logic [63:0] m;
      p = longint'(a) * longint'(b);
      m = (64'd1 << (2 * w)) - 64'd1;
      return m & p;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step10(input logic v, input int a, input int b);
      @(negedge clk);
      in_valid10 = v;
      if (v) begin
         A10 = a[9:0];
         B10 = b[9:0];
         q10.push_back(prod(a, b, 10));
      end else begin
         A10 = 'x;
         B10 = 'x;
      end
   endtask

   task automatic corner(input int a, input int b, input logic [63:0] exp);
      step10(1'b1, a, b);
      step10(1'b0, 0, 0);
      chk("corner_lat1_ov", 64'(ov10), 64'd0);
      step10(1'b0, 0, 0);
      chk("corner_ov", 64'(ov10), 64'd1);
      chk("corner_p", 64'(P10), exp);
   endtask

   task automatic step_sw(input int i);
      int a, b;
      @(negedge clk);
      a = (i >> 5) - 16;
      b = (i & 31) - 16;
      in_valid5 = 1'b1;
      A5 = a[4:0];
      B5 = b[4:0];
      q5.push_back(prod(a, b, 5));
      if (i < 256) begin
         a = (i >> 4) - 8;
         b = (i & 15) - 8;
         in_valid4 = 1'b1;
         A4 = a[3:0];
         B4 = b[3:0];
         q4.push_back(prod(a, b, 4));
      end else begin
         in_valid4 = 1'b0;
         A4 = 'x;
         B4 = 'x;
      end
   endtask

   // Scoreboard: every out_valid pops the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (ov10 === 1'b1) begin
            chk("sb10_pending", 64'(q10.size() != 0), 64'd1);
            if (q10.size() != 0) chk("sb10_p", 64'(P10), q10.pop_front());
         end
         if (ov4 === 1'b1) begin
            chk("sb4_pending", 64'(q4.size() != 0), 64'd1);
            if (q4.size() != 0) chk("sb4_p", 64'(P4), q4.pop_front());
         end
         if (ov5 === 1'b1) begin
            chk("sb5_pending", 64'(q5.size() != 0), 64'd1);
            if (q5.size() != 0) chk("sb5_p", 64'(P5), q5.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, b;
      rst_n = 1'b1;
      in_valid10 = 1'b0; A10 = '0; B10 = '0;
      in_valid4  = 1'b0; A4  = '0; B4  = '0;
      in_valid5  = 1'b0; A5  = '0; B5  = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("reset_p10", 64'(P10), 64'd0);
      chk("reset_ov10", 64'(ov10), 64'd0);
      chk("reset_p5", 64'(P5), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      corner(-512, -512, 64'h40000);
      corner(511, -512, 64'hC0200);
      corner(-1, -1, 64'h1);
      corner(0, -300, 64'h0);

      for (int i = 0; i < 50; i++) begin
         a = int'($urandom_range(1023)) - 512;
         b = int'($urandom_range(1023)) - 512;
         step10(1'b1, a, b);
         if (i >= 2) chk("stream_ov", 64'(ov10), 64'd1);
      end
      step10(1'b0, 0, 0);
      chk("stream_tail_ov", 64'(ov10), 64'd1);
      step10(1'b0, 0, 0);
      chk("stream_tail2_ov", 64'(ov10), 64'd1);
      step10(1'b0, 0, 0);
      chk("stream_idle_ov", 64'(ov10), 64'd0);

      step10(1'b1, 3, -7);
      step10(1'b0, 0, 0);
      step10(1'b1, 100, 100);
      chk("bubble_ov_a", 64'(ov10), 64'd1);
      chk("bubble_p_a", 64'(P10), 64'hFFFEB);
      step10(1'b0, 0, 0);
      chk("bubble_ov_gap", 64'(ov10), 64'd0);
      chk("bubble_p_hold", 64'(P10), 64'hFFFEB);
      step10(1'b0, 0, 0);
      chk("bubble_ov_c", 64'(ov10), 64'd1);
      chk("bubble_p_c", 64'(P10), 64'd10000);

      step10(1'b1, 5, 5);
      step10(1'b0, 0, 0);
      #2 rst_n = 1'b0;
      q10.delete();
      q4.delete();
      q5.delete();
      #1;
      chk("midrst_p", 64'(P10), 64'd0);
      chk("midrst_ov", 64'(ov10), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step10(1'b0, 0, 0);
      chk("postrst_ov", 64'(ov10), 64'd0);
      chk("postrst_p", 64'(P10), 64'd0);
      step10(1'b1, -123, 45);
      chk("postrst_ov2", 64'(ov10), 64'd0);
      step10(1'b0, 0, 0);
      chk("postrst_lat1_ov", 64'(ov10), 64'd0);
      step10(1'b0, 0, 0);
      chk("postrst_res_ov", 64'(ov10), 64'd1);
      chk("postrst_res_p", 64'(P10), prod(-123, 45, 10));

      for (int i = 0; i < 1024; i++) step_sw(i);
      @(negedge clk);
      in_valid4 = 1'b0; A4 = 'x; B4 = 'x;
      in_valid5 = 1'b0; A5 = 'x; B5 = 'x;

      for (int k = 0; k < 10 && (q10.size() + q4.size() + q5.size()) != 0; k++)
         @(posedge clk);
      @(posedge clk);
      #1;
      chk("drain10", 64'(q10.size()), 64'd0);
      chk("drain4", 64'(q4.size()), 64'd0);
      chk("drain5", 64'(q5.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/multi_signed.md
Name: multi_signed

Overview:
- Pipelined two's-complement signed multiplier: P = A × B, exact full-precision product.
- Datapath arithmetic block, one clock domain, asynchronous active-low reset.
- Fixed 2-cycle latency, one new operand pair accepted every cycle.
- Internal structure: radix-4 Booth partial products plus an adder tree, with registered input and output stages.

Parameters:
- width, 10, operand width in bits (≥ 4). Product width is 2*width.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, A/B valid this cycle.
- A, input, width, signed multiplicand (two's complement).
- B, input, width, signed multiplier (two's complement).
- out_valid, output, 1, P holds a new product this cycle.
- P, output, 2*width, signed product (two's complement).

Behaviour:
- Interface fixed: one clock (clk); rst_n is asynchronous, active-low.
- Reset: while rst_n = 0, all pipeline registers clear immediately, independent of clk: P = 0, out_valid = 0, internal valid bits = 0.
- First active clock edge occurs after rst_n deasserts.
- Stage 1, edge N:
  - If in_valid = 1, capture A, B.
  - s1_valid ← in_valid on every edge.
- Stage 2, edge N+1:
  - If s1_valid = 1, compute the Booth product of the stage-1 operands and load P.
  - out_valid ← s1_valid on every edge.
- Latency: operands presented with in_valid high before edge N appear on P with out_valid high after edge N+1, i.e. 2 clocks.
- Throughput: 1 product per cycle. No back-pressure and no ready signal.
- Hold behaviour:
  - P keeps the last valid product when out_valid = 0.
  - Stage-1 operand registers hold their value when in_valid = 0.
- Arithmetic:
  - Operands sign-extended to 2*width before accumulation.
  - Radix-4 Booth encoding, ceil(width/2) partial products.
  - Booth digits {-2, -1, 0, +1, +2}, with -X formed as ~X + 1.
- Result: bit-exact with the signed product of A and B, truncated to 2*width bits. No overflow is possible, including A = B = -2^(width-1), which gives +2^(2*width-2).
- Odd width: B is sign-extended by one bit before Booth recoding.
- Reset mid-operation: in-flight products are discarded and out_valid stays 0 until 2 edges after the next in_valid.
- X/Z on A or B while in_valid = 0 must not propagate to P.

Test Plan:
- Reset check: assert rst_n = 0 mid-clock -> P = 0 and out_valid = 0 immediately, without waiting for a clock edge.
- Corner products (width = 10): (-512)×(-512) -> P = 20'h40000; 511×(-512) -> -261632 = 20'hC0200; (-1)×(-1) -> 1; 0×(-300) -> 0. Each appears 2 edges after its in_valid, with out_valid = 1.
- Streaming: apply 50 random A/B pairs back-to-back with in_valid = 1 -> out_valid high from the 2nd edge onward, and each P equals the signed product of the pair issued 2 cycles earlier.
- Bubbles: in_valid pattern 1,0,1 with 3×(-7) then 100×100 -> out_valid pattern 1,0,1; P = -21, held at -21 during the bubble, then 10000.
- Reset mid-pipe: issue 5×5, drop rst_n for one cycle before the result emerges -> out_valid stays 0 and P = 0; the next issued pair is correct after 2 edges.
- Parameter sweep: width = 4 (odd-width variant: width = 5) with exhaustive operand pairs -> every P equals the exact signed product.
